// File: rtl/pattern_search_engine_if.sv
// Control, memory-read and match-handshake bundle of the pattern search engine.
// The engine connects to the slave modport; board control and memory use the master side.
interface pattern_search_engine_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] pat_base;
    logic [ADDR_W-1:0] pat_len;
    logic [ADDR_W-1:0] blk_base;
    logic [ADDR_W-1:0] blk_len;
    logic              find_all;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              match_valid;
    logic [ADDR_W-1:0] match_addr;
    logic              match_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] match_count;

    modport slave (
        input  start, pat_base, pat_len, blk_base, blk_len, find_all,
        input  mem_rdata, match_ready,
        output mem_en, mem_addr, match_valid, match_addr,
        output busy, done, err, match_count
    );

    modport master (
        output start, pat_base, pat_len, blk_base, blk_len, find_all,
        output mem_rdata, match_ready,
        input  mem_en, mem_addr, match_valid, match_addr,
        input  busy, done, err, match_count
    );
endinterface

// File: rtl/pattern_search_engine.sv
// Loads a pattern from memory, then scans a block for every (overlapping) occurrence,
// one memory read outstanding at a time, reporting match addresses via valid/ready.
module pattern_search_engine #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_PAT_LEN = 16,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned WILDCARD_EN = 0,
    parameter logic [31:0] WILDCARD    = 32'h0000_003F
) (
    input  logic                     clk,
    input  logic                     reset,
    pattern_search_engine_if.slave   bus
);

    localparam int unsigned IDX_W = (MAX_PAT_LEN > 1) ? $clog2(MAX_PAT_LEN) : 1;
    localparam logic [ADDR_W:0]   MAXP   = (ADDR_W+1)'(MAX_PAT_LEN);
    localparam logic [1:0]        LAT    = 2'(MEM_LATENCY);
    localparam logic [DATA_W-1:0] WC     = DATA_W'(WILDCARD);
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ONES_A = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD_REQ, S_LOAD_WAIT, S_CMP_REQ, S_CMP_WAIT, S_REPORT, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pat_base_q, pat_base_d, pat_len_q, pat_len_d;
    logic [ADDR_W-1:0] blk_base_q, blk_base_d, blk_len_q, blk_len_d;
    logic              find_all_q, find_all_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d, rem_q, rem_d;
    logic [1:0]        lat_q, lat_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              match_valid_q, match_valid_d;
    logic [ADDR_W-1:0] match_addr_q, match_addr_d, match_count_q, match_count_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0] pat_q [MAX_PAT_LEN];
    logic              pat_we_s;

    function automatic logic word_match(input logic [DATA_W-1:0] rd,
                                        input logic [DATA_W-1:0] pw);
        logic wc_hit;
        wc_hit = (WILDCARD_EN != 32'd0) && (pw == WC);
        return (rd == pw) || wc_hit;
    endfunction

    // Next-state and output decode; rem_q counts start positions still to try.
    always_comb begin
        state_d       = state_q;
        pat_base_d    = pat_base_q;
        pat_len_d     = pat_len_q;
        blk_base_d    = blk_base_q;
        blk_len_d     = blk_len_q;
        find_all_d    = find_all_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        rem_d         = rem_q;
        lat_d         = lat_q;
        mem_en_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        match_valid_d = match_valid_q;
        match_addr_d  = match_addr_q;
        match_count_d = match_count_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        pat_we_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pat_base_d    = bus.pat_base;
                    pat_len_d     = bus.pat_len;
                    blk_base_d    = bus.blk_base;
                    blk_len_d     = bus.blk_len;
                    find_all_d    = bus.find_all;
                    done_d        = 1'b0;
                    err_d         = 1'b0;
                    match_count_d = ZERO_A;
                    busy_d        = 1'b1;
                    state_d       = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if ((pat_len_q == ZERO_A) || ({1'b0, pat_len_q} > MAXP) ||
                    (pat_len_q > blk_len_q)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    i_d     = blk_base_q;
                    k_d     = ZERO_A;
                    rem_d   = blk_len_q - pat_len_q;
                    state_d = S_LOAD_REQ;
                end
            end
            S_LOAD_REQ: begin
                mem_en_d   = 1'b1;
                mem_addr_d = pat_base_q + k_q;
                lat_d      = 2'd0;
                state_d    = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                if (lat_q == LAT) begin
                    pat_we_s = 1'b1;
                    if (k_q == pat_len_q - ONE_A) begin
                        j_d     = ZERO_A;
                        state_d = S_CMP_REQ;
                    end else begin
                        k_d     = k_q + ONE_A;
                        state_d = S_LOAD_REQ;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_CMP_REQ: begin
                mem_en_d   = 1'b1;
                mem_addr_d = i_q + j_q;
                lat_d      = 2'd0;
                state_d    = S_CMP_WAIT;
            end
            S_CMP_WAIT: begin
                if (lat_q != LAT) begin
                    lat_d = lat_q + 2'd1;
                end else if (word_match(bus.mem_rdata, pat_q[j_q[IDX_W-1:0]])) begin
                    if (j_q == pat_len_q - ONE_A) begin
                        match_valid_d = 1'b1;
                        match_addr_d  = i_q;
                        match_count_d = (match_count_q == ONES_A) ? ONES_A
                                                                  : match_count_q + ONE_A;
                        state_d       = S_REPORT;
                    end else begin
                        j_d     = j_q + ONE_A;
                        state_d = S_CMP_REQ;
                    end
                end else if (rem_q == ZERO_A) begin
                    state_d = S_FIN;
                end else begin
                    i_d     = i_q + ONE_A;
                    j_d     = ZERO_A;
                    rem_d   = rem_q - ONE_A;
                    state_d = S_CMP_REQ;
                end
            end
            S_REPORT: begin
                if (!bus.match_ready) begin
                    state_d = S_REPORT;
                end else if (!find_all_q || (rem_q == ZERO_A)) begin
                    match_valid_d = 1'b0;
                    state_d       = S_FIN;
                end else begin
                    match_valid_d = 1'b0;
                    i_d           = i_q + ONE_A;
                    j_d           = ZERO_A;
                    rem_d         = rem_q - ONE_A;
                    state_d       = S_CMP_REQ;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pat_base_q    <= ZERO_A;
            pat_len_q     <= ZERO_A;
            blk_base_q    <= ZERO_A;
            blk_len_q     <= ZERO_A;
            find_all_q    <= 1'b0;
            i_q           <= ZERO_A;
            j_q           <= ZERO_A;
            k_q           <= ZERO_A;
            rem_q         <= ZERO_A;
            lat_q         <= 2'd0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= ZERO_A;
            match_valid_q <= 1'b0;
            match_addr_q  <= ZERO_A;
            match_count_q <= ZERO_A;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pat_base_q    <= pat_base_d;
            pat_len_q     <= pat_len_d;
            blk_base_q    <= blk_base_d;
            blk_len_q     <= blk_len_d;
            find_all_q    <= find_all_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            rem_q         <= rem_d;
            lat_q         <= lat_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            match_valid_q <= match_valid_d;
            match_addr_q  <= match_addr_d;
            match_count_q <= match_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Pattern buffer; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (pat_we_s) begin
            pat_q[k_q[IDX_W-1:0]] <= bus.mem_rdata;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.match_valid = match_valid_q;
    assign bus.match_addr  = match_addr_q;
    assign bus.match_count = match_count_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_pattern_search_engine.sv
// Directed bench for pattern_search_engine: latency-1 memory model, handshake monitor,
// hand-computed match addresses, counts and memory-read totals.
module tb_pattern_search_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_search_engine_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    pattern_search_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_mem_en = 0;
    int         n_valid = 0;
    logic [7:0] hs_q [$];

    // Memory with one cycle read latency plus handshake/read monitors.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (!reset) begin
            if (bus.mem_en) n_mem_en <= n_mem_en + 1;
            if (bus.match_valid) n_valid <= n_valid + 1;
            if (bus.match_valid && bus.match_ready) hs_q.push_back(bus.match_addr);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        n_mem_en = 0;
        n_valid  = 0;
        hs_q.delete();
    endtask

    task automatic run_search(input logic [7:0] pb, input logic [7:0] pl, input logic [7:0] bb,
                              input logic [7:0] bl, input logic fa);
        @(negedge clk);
        bus.pat_base = pb;
        bus.pat_len  = pl;
        bus.blk_base = bb;
        bus.blk_len  = bl;
        bus.find_all = fa;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!bus.done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check_val({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!bus.match_valid && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check_val({tag, "_valid"}, {31'd0, bus.match_valid}, 32'd1);
    endtask

    task automatic check_matches(input string tag, input int n_exp, input logic [7:0] a0,
                                 input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0] exp_a [3];
        exp_a[0] = a0;
        exp_a[1] = a1;
        exp_a[2] = a2;
        check_val({tag, "_nmatch"}, hs_q.size(), n_exp);
        for (int m = 0; m < n_exp && m < hs_q.size(); m++)
            check_val($sformatf("%s_addr%0d", tag, m), {24'd0, hs_q[m]}, {24'd0, exp_a[m]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"},  {31'd0, bus.busy},        32'd0);
        check_val({tag, "_done"},  {31'd0, bus.done},        32'd0);
        check_val({tag, "_err"},   {31'd0, bus.err},         32'd0);
        check_val({tag, "_valid"}, {31'd0, bus.match_valid}, 32'd0);
        check_val({tag, "_maddr"}, {24'd0, bus.match_addr},  32'd0);
        check_val({tag, "_count"}, {24'd0, bus.match_count}, 32'd0);
        check_val({tag, "_men"},   {31'd0, bus.mem_en},      32'd0);
        check_val({tag, "_addr"},  {24'd0, bus.mem_addr},    32'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2; mem[8'h02] = 8'hC3;
        mem[8'h14] = 8'hA1; mem[8'h15] = 8'hB2; mem[8'h16] = 8'hC3;
        for (int a = 8'h20; a < 8'h24; a++) mem[a] = 8'h55;
        mem[8'h30] = 8'h55; mem[8'h31] = 8'h55;
        mem[8'h40] = 8'h11; mem[8'h41] = 8'hA1;
        mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h11;

        bus.start = 1'b0; bus.pat_base = 8'h00; bus.pat_len = 8'h00;
        bus.blk_base = 8'h00; bus.blk_len = 8'h00; bus.find_all = 1'b0;
        bus.match_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst");

        // Single match inside a 16-word block: 3 pattern loads + 13 one-read misses + 3 reads.
        clear_mon();
        run_search(8'h00, 8'd3, 8'h10, 8'd16, 1'b1);
        wait_done("t1");
        check_matches("t1", 1, 8'h14, 8'h00, 8'h00);
        check_val("t1_err",   {31'd0, bus.err},         32'd0);
        check_val("t1_count", {24'd0, bus.match_count}, 32'd1);
        check_val("t1_busy",  {31'd0, bus.busy},        32'd0);
        check_val("t1_vcyc",  n_valid,                  32'd1);
        check_val("t1_reads", n_mem_en,                 32'd19);

        // Overlapping matches, find_all=1.
        clear_mon();
        run_search(8'h30, 8'd2, 8'h20, 8'd4, 1'b1);
        wait_done("t2");
        check_matches("t2", 3, 8'h20, 8'h21, 8'h22);
        check_val("t2_count", {24'd0, bus.match_count}, 32'd3);
        check_val("t2_reads", n_mem_en,                 32'd8);

        // First match only; no reads after the handshake.
        clear_mon();
        run_search(8'h30, 8'd2, 8'h20, 8'd4, 1'b0);
        wait_done("t3");
        check_matches("t3", 1, 8'h20, 8'h00, 8'h00);
        check_val("t3_count", {24'd0, bus.match_count}, 32'd1);
        check_val("t3_reads", n_mem_en,                 32'd4);

        // Back-pressure for 5 cycles.
        clear_mon();
        bus.match_ready = 1'b0;
        run_search(8'h30, 8'd2, 8'h20, 8'd4, 1'b0);
        wait_valid("t4");
        for (int c = 0; c < 5; c++) begin
            check_val($sformatf("t4_hold_valid%0d", c), {31'd0, bus.match_valid}, 32'd1);
            check_val($sformatf("t4_hold_addr%0d", c),  {24'd0, bus.match_addr},  32'h20);
            check_val($sformatf("t4_hold_men%0d", c),   {31'd0, bus.mem_en},      32'd0);
            @(negedge clk);
        end
        check_val("t4_reads_held", n_mem_en, 32'd4);
        bus.match_ready = 1'b1;
        @(negedge clk);
        check_val("t4_valid_drop", {31'd0, bus.match_valid}, 32'd0);
        wait_done("t4");
        check_matches("t4", 1, 8'h20, 8'h00, 8'h00);
        check_val("t4_reads", n_mem_en, 32'd4);

        // Illegal lengths.
        clear_mon();
        run_search(8'h00, 8'd0, 8'h10, 8'd16, 1'b1);
        wait_done("t5a");
        check_val("t5a_err",   {31'd0, bus.err},         32'd1);
        check_val("t5a_count", {24'd0, bus.match_count}, 32'd0);
        check_val("t5a_reads", n_mem_en,                 32'd0);
        clear_mon();
        run_search(8'h00, 8'd5, 8'h10, 8'd4, 1'b1);
        wait_done("t5b");
        check_val("t5b_err",   {31'd0, bus.err},         32'd1);
        check_val("t5b_reads", n_mem_en,                 32'd0);
        clear_mon();
        run_search(8'h30, 8'd2, 8'h20, 8'd4, 1'b1);
        check_val("t5c_err_clr",  {31'd0, bus.err},  32'd0);
        check_val("t5c_done_clr", {31'd0, bus.done}, 32'd0);
        check_val("t5c_busy",     {31'd0, bus.busy}, 32'd1);
        wait_done("t5c");
        check_val("t5c_count", {24'd0, bus.match_count}, 32'd3);

        // Block wrapping past 0xFF: positions FE, FF, 00.
        clear_mon();
        run_search(8'h40, 8'd2, 8'hFE, 8'd4, 1'b1);
        wait_done("t6");
        check_matches("t6", 1, 8'hFF, 8'h00, 8'h00);
        check_val("t6_reads", n_mem_en, 32'd6);

        // Reset with a pending match, then a fresh search.
        bus.match_ready = 1'b0;
        run_search(8'h40, 8'd2, 8'hFE, 8'd4, 1'b1);
        wait_valid("t7");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("t7_rst");
        bus.match_ready = 1'b1;
        clear_mon();
        run_search(8'h30, 8'd2, 8'h20, 8'd4, 1'b1);
        wait_done("t7");
        check_matches("t7", 3, 8'h20, 8'h21, 8'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
